// File: rtl/counter_sync_pkg.sv
// rtl/counter_sync_pkg.sv - shared defaults, legal-range limits and Gray helpers
// for counter_sync_param (optional Gray I/O enabled by COUNTER_SYNC_GRAY_EN).
package counter_sync_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int MOD_DEF   = 10;
   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 16;
   localparam int MOD_MIN   = 2;

   function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [WIDTH_MAX-1:0] gray2bin(input logic [WIDTH_MAX-1:0] g);
      logic [WIDTH_MAX-1:0] b;
      b[WIDTH_MAX-1] = g[WIDTH_MAX-1];
      for (int i = WIDTH_MAX - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/counter_code_conv.sv
// rtl/counter_code_conv.sv - binary-to-Gray and Gray-to-binary converters,
// instantiated by counter_sync_param only when COUNTER_SYNC_GRAY_EN is defined.
module counter_code_conv
   import counter_sync_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] i_bin,
   output logic [WIDTH-1:0] o_gray,
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   // Zero-extension to the package width is harmless in both directions.
   assign o_gray = WIDTH'(bin2gray(WIDTH_MAX'(i_bin)));
   assign o_bin  = WIDTH'(gray2bin(WIDTH_MAX'(i_gray)));

endmodule

// File: rtl/counter_sync_param.sv
// rtl/counter_sync_param.sv - modulo-MOD up/down counter with load, terminal-count
// and bad-load flags; Gray-coded Data/Data_out when COUNTER_SYNC_GRAY_EN is defined.
module counter_sync_param
   import counter_sync_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int MOD   = MOD_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Load,
   input  logic [WIDTH-1:0] Data,
   input  logic             En,
   input  logic             Up,
   output logic [WIDTH-1:0] Data_out,
   output logic             TC,
   output logic             Err
);

   // One extra bit so MOD == 2**WIDTH is representable for the wrap compare.
   localparam logic [WIDTH:0]   L_MOD    = (WIDTH+1)'(MOD);
   localparam logic [WIDTH-1:0] L_MOD_M1 = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_err;

   logic [WIDTH-1:0] w_data_bin;
   logic [WIDTH:0]   w_inc_ext;
   logic [WIDTH-1:0] w_next;
   logic             w_tc_next;
   logic             w_err_next;

`ifdef COUNTER_SYNC_GRAY_EN
   logic [WIDTH-1:0] w_next_gray;
   logic [WIDTH-1:0] r_data_gray;

   counter_code_conv #(
      .WIDTH (WIDTH)
   ) u_conv (
      .i_bin  (w_next),
      .o_gray (w_next_gray),
      .i_gray (Data),
      .o_bin  (w_data_bin)
   );

   // Gray output is registered alongside the count so Data_out stays glitch-free.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_data_gray <= '0;
      end else begin
         r_data_gray <= w_next_gray;
      end
   end

   assign Data_out = r_data_gray;
`else
   assign w_data_bin = Data;
   assign Data_out   = r_count;
`endif

   assign w_inc_ext = {1'b0, r_count} + (WIDTH+1)'(1);

   always_comb begin
      w_next     = r_count;
      w_tc_next  = 1'b0;
      w_err_next = 1'b0;
      if (Load) begin
         if ({1'b0, w_data_bin} >= L_MOD) begin
            w_next     = '0;
            w_err_next = 1'b1;
         end else begin
            w_next = w_data_bin;
         end
      end else if (En) begin
         if (Up) begin
            if (w_inc_ext == L_MOD) begin
               w_next    = '0;
               w_tc_next = 1'b1;
            end else begin
               w_next = w_inc_ext[WIDTH-1:0];
            end
         end else begin
            if (r_count == '0) begin
               w_next    = L_MOD_M1;
               w_tc_next = 1'b1;
            end else begin
               w_next = r_count - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_count <= '0;
         r_tc    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_count <= w_next;
         r_tc    <= w_tc_next;
         r_err   <= w_err_next;
      end
   end

   assign TC  = r_tc;
   assign Err = r_err;

endmodule

// File: tb/tb_counter_sync_param.sv
// tb/tb_counter_sync_param.sv - scoreboard bench for counter_sync_param with modulus-10 and full-range instances
module tb_counter_sync_param;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       load_a = 1'b0, en_a = 1'b0, up_a = 1'b0;
   logic [3:0] data_a = '0;
   logic [3:0] out_a;
   logic       tc_a, err_a;
   logic       load_b = 1'b0, en_b = 1'b0, up_b = 1'b0;
   logic [3:0] data_b = '0;
   logic [3:0] out_b;
   logic       tc_b, err_b;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [3:0] cnt;
      logic       tc;
      logic       err;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   counter_sync_param #(.WIDTH(4), .MOD(10)) u_dut_a (
      .CLK(CLK), .RST(RST), .Load(load_a), .Data(data_a), .En(en_a), .Up(up_a),
      .Data_out(out_a), .TC(tc_a), .Err(err_a)
   );

   counter_sync_param #(.WIDTH(4), .MOD(16)) u_dut_b (
      .CLK(CLK), .RST(RST), .Load(load_b), .Data(data_b), .En(en_b), .Up(up_b),
      .Data_out(out_b), .TC(tc_b), .Err(err_b)
   );

   always #5 CLK = ~CLK;

   function automatic logic [3:0] enc(input logic [3:0] b);
`ifdef COUNTER_SYNC_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_a(input logic ld, input logic [3:0] d, input logic en, input logic up,
                          input logic [3:0] e_cnt, input logic e_tc, input logic e_err);
      @(negedge CLK);
      load_a = ld; data_a = enc(d); en_a = en; up_a = up;
      qa.push_back('{cnt: e_cnt, tc: e_tc, err: e_err});
   endtask

   task automatic drive_b(input logic ld, input logic [3:0] d, input logic en, input logic up,
                          input logic [3:0] e_cnt, input logic e_tc, input logic e_err);
      @(negedge CLK);
      load_b = ld; data_b = enc(d); en_b = en; up_b = up;
      qb.push_back('{cnt: e_cnt, tc: e_tc, err: e_err});
   endtask

   // Monitor: every rising edge produces one output sample per instance.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_data_out", 32'(out_a), 32'(enc(e.cnt)));
            chk("a_tc", 32'(tc_a), 32'(e.tc));
            chk("a_err", 32'(err_a), 32'(e.err));
         end
         if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_data_out", 32'(out_b), 32'(enc(e.cnt)));
            chk("b_tc", 32'(tc_b), 32'(e.tc));
            chk("b_err", 32'(err_b), 32'(e.err));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("rst_data_out", 32'(out_a), 32'(0));
      chk("rst_tc", 32'(tc_a), 32'(0));
      chk("rst_err", 32'(err_a), 32'(0));
      @(negedge CLK);
      RST = 1'b0;

      //       ld  data en up   cnt tc err
      drive_a(1, 8,  0, 0,   8, 0, 0);
      drive_a(0, 0,  1, 1,   9, 0, 0);
      drive_a(0, 0,  1, 1,   0, 1, 0);
      drive_a(0, 0,  1, 1,   1, 0, 0);
      drive_a(1, 1,  0, 0,   1, 0, 0);
      drive_a(0, 0,  1, 0,   0, 0, 0);
      drive_a(0, 0,  1, 0,   9, 1, 0);
      drive_a(0, 0,  1, 0,   8, 0, 0);
      drive_a(1, 12, 0, 0,   0, 0, 1);
      drive_a(0, 0,  0, 0,   0, 0, 0);
      drive_a(1, 5,  0, 0,   5, 0, 0);
      drive_a(1, 3,  1, 1,   3, 0, 0);
      for (int i = 0; i < 5; i++) drive_a(0, 0, 0, 1, 3, 0, 0);
      drive_a(1, 9,  0, 0,   9, 0, 0);
      drive_a(1, 10, 1, 1,   0, 0, 1);
      drive_a(1, 15, 0, 0,   0, 0, 1);
      drive_a(0, 0,  1, 0,   9, 1, 0);
      drive_a(1, 0,  0, 0,   0, 0, 0);
      drive_a(1, 6,  0, 0,   6, 0, 0);
      drive_a(0, 0,  1, 1,   7, 0, 0);

      // Asynchronous reset mid-count at 7, then inputs ignored while held.
      @(negedge CLK);
      load_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
      #2 RST = 1'b1;
      #1;
      chk("async_rst_data_out", 32'(out_a), 32'(0));
      chk("async_rst_tc", 32'(tc_a), 32'(0));
      chk("async_rst_err", 32'(err_a), 32'(0));
      load_a = 1'b1; data_a = enc(4'd5);
      @(posedge CLK);
      #1;
      chk("held_rst_data_out", 32'(out_a), 32'(0));
      @(negedge CLK);
      RST = 1'b0; load_a = 1'b0; en_a = 1'b0;
      drive_a(0, 0,  1, 1,   1, 0, 0);
      drive_a(0, 0,  0, 0,   1, 0, 0);

      // Full-range instance: MOD = 2**WIDTH.
      drive_b(1, 14, 0, 0,  14, 0, 0);
      drive_b(0, 0,  1, 1,  15, 0, 0);
      drive_b(0, 0,  1, 1,   0, 1, 0);
      drive_b(0, 0,  1, 0,  15, 1, 0);
      drive_b(0, 0,  1, 0,  14, 0, 0);
      drive_b(1, 15, 1, 1,  15, 0, 0);
      drive_b(0, 0,  0, 0,  15, 0, 0);

      repeat (3) @(negedge CLK);
      chk("qa_drained", 32'(qa.size()), 32'(0));
      chk("qb_drained", 32'(qb.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_sync_param.md
COUNTER_SYNC_PARAM -- requirements
Module: counter_sync_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter and data width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter MOD, default 10, giving the count modulus; the count range is 0..MOD-1 (legal range 2..2^WIDTH).
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit, the reset: asynchronous, active-high.
REQ-005 The block SHALL have port Load, input, 1 bit, a synchronous parallel-load request.
REQ-006 The block SHALL have port Data, input, WIDTH bits, the value to load.
REQ-007 The block SHALL have port En, input, 1 bit, the count enable.
REQ-008 The block SHALL have port Up, input, 1 bit, the direction: 1 counts up, 0 counts down.
REQ-009 The block SHALL have port Data_out, output, WIDTH bits, the registered count value.
REQ-010 The block SHALL have port TC, output, 1 bit, the registered terminal-count flag.
REQ-011 The block SHALL have port Err, output, 1 bit, a one-cycle pulse flagging an out-of-range load.

Function
REQ-012 Per-edge priority SHALL be RST > Load > En > hold.
REQ-013 Load with Data < MOD SHALL set the count to Data on that edge.
REQ-014 Load with Data >= MOD SHALL set the count to 0 and pulse Err high for exactly the following cycle.
REQ-015 En=1, Up=1 SHALL increment the count, wrapping MOD-1 -> 0.
REQ-016 En=1, Up=0 SHALL decrement the count, wrapping 0 -> MOD-1.
REQ-017 En=0 with Load=0 SHALL hold the count; TC and Err SHALL be 0 that cycle.
REQ-018 TC SHALL be 1 for the cycle after an edge on which the counter wrapped (MOD-1 -> 0 up, 0 -> MOD-1 down); a wrap caused by Load SHALL NOT set TC.
REQ-019 Arithmetic SHALL be performed in WIDTH+1 bits internally so that MOD = 2^WIDTH wraps correctly with no overflow.
REQ-020 Data_out SHALL change only on a CLK edge or on RST assertion, giving a latency of one cycle from Load or En to Data_out.
REQ-021 Simultaneous Load and En SHALL load only; no count step occurs on that edge.

Reset
REQ-022 RST assertion SHALL immediately force the count to 0, Data_out to 0 (encoded per REQ-024), and TC and Err to 0, regardless of CLK.
REQ-023 While RST is high, Load and En SHALL be ignored; counting SHALL resume on the first CLK edge after deassertion.

Configuration
REQ-024 With macro COUNTER_SYNC_GRAY_EN defined, Data_out SHALL present the count in reflected Gray code and Data SHALL be interpreted as Gray code, decoded to binary before the range check.
REQ-025 Without COUNTER_SYNC_GRAY_EN, Data and Data_out SHALL be plain binary and no code-conversion logic SHALL be instantiated.

Structure
REQ-026 Shared package counter_sync_pkg SHALL hold the WIDTH and MOD defaults, the legal-range limit constants, and the binary/Gray conversion functions.
REQ-027 Code conversion SHALL live in one sub-module, counter_code_conv (bin2gray and gray2bin), instantiated only under COUNTER_SYNC_GRAY_EN.
REQ-028 The count register, the next-state adder/subtractor and the flag logic SHALL reside in counter_sync_param.

Verification
REQ-029 Reset: RST pulse mid-count at count=7 -> Data_out=0, TC=0, Err=0 immediately, before any CLK edge.
REQ-030 Up-wrap: WIDTH=4, MOD=10, Load 8, then En=1, Up=1 for 3 edges -> Data_out 9, 0, 1; TC=1 only in the cycle showing 0.
REQ-031 Down-wrap: Load 1, En=1, Up=0 for 2 edges -> Data_out 0, 9; TC=1 only in the cycle showing 9.
REQ-032 Bad load: Load Data=12 with MOD=10 -> Data_out=0, Err=1 for one cycle; with Data=5 -> Data_out=5, Err=0.
REQ-033 Priority: Load=1, En=1, Data=3 -> Data_out=3 with no step; Load=0, En=0 -> Data_out holds 3 for 5 edges.
REQ-034 Full range and Gray: WIDTH=4, MOD=16, count 15 -> 0 with TC=1; with COUNTER_SYNC_GRAY_EN defined, count 15 -> Data_out 4'b1000.
